// File: rtl/next_queue_pkg.sv
// Shared types and widths for the next_queue block: entry layout, widths and
// the gc sign-extension helper.
package next_queue_pkg;

    localparam int ROB_WIDTH    = 6;
    localparam int GC_WIDTH     = 16;
    localparam int N_B_ENTRY    = 4;
    localparam int BC_WIDTH     = $clog2(N_B_ENTRY) + 1;
    localparam int N_NEXT_ENTRY = 4;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [BC_WIDTH-1:0]  b_count;
    } next_entry_t;

    function automatic logic [31:0] sext_gc(input logic [GC_WIDTH-1:0] v);
        return 32'($signed(v));
    endfunction

endpackage

// File: rtl/next_queue_if.sv
// Valid/ready handshake bundle used for the issue, gc fetch and GPR CDB ports.
interface next_queue_if;
    logic valid;
    logic ready;

    modport master (output valid, input ready);
    modport slave  (input valid, output ready);
endinterface

// File: rtl/next_queue_slot.sv
// next_slot: one queued next instruction; ages its pending-branch count on
// every branch commit and reports whether it is confirmed or survives a flush.
module next_slot
    import next_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_write,
    input  logic [ROB_WIDTH-1:0] i_tag,
    input  logic [BC_WIDTH-1:0]  i_b_count,
    input  logic                 i_clear,
    input  logic                 i_flush,
    input  logic                 i_b_commit,
    output logic [ROB_WIDTH-1:0] o_tag,
    output logic                 o_confirmed,
    output logic                 o_survive
);

    next_entry_t         r_entry;
    logic [BC_WIDTH-1:0] w_bc_aged;

    // Saturating decrement: a resolved entry never goes negative.
    assign w_bc_aged   = (r_entry.b_count == '0) ? '0
                       : r_entry.b_count - BC_WIDTH'(i_b_commit);
    assign o_confirmed = r_entry.valid && (w_bc_aged == '0);
    assign o_survive   = r_entry.valid && (r_entry.b_count == '0);
    assign o_tag       = r_entry.tag;

    // Entry state: a new write wins over a same-cycle dequeue of the old occupant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '0;
        end else if (i_write) begin
            r_entry.valid   <= 1'b1;
            r_entry.tag     <= i_tag;
            r_entry.b_count <= i_b_count;
        end else if (i_clear || (i_flush && !o_survive)) begin
            r_entry.valid <= 1'b0;
        end else if (r_entry.valid) begin
            r_entry.b_count <= w_bc_aged;
        end else begin
            r_entry <= r_entry;
        end
    end

endmodule

// File: rtl/next_queue.sv
// next_queue: in-order queue of next instructions that fetches gc and
// broadcasts it on the GPR CDB once the head is non-speculative.
// Optional feature macro: NEXT_BYPASS_EN (empty-queue same-cycle dispatch).
module next_queue
    import next_queue_pkg::*;
#(
    parameter int DEPTH = N_NEXT_ENTRY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROB_WIDTH-1:0]   gpr_issue_tag,
    input  logic [BC_WIDTH-1:0]    b_count_next,
    input  logic                   b_commit,
    input  logic                   failure,
    next_queue_if.slave            issue_req,
    next_queue_if.master           gc_req,
    next_queue_if.master           gpr_cdb_req,
    input  logic [GC_WIDTH-1:0]    gc,
    output logic [ROB_WIDTH-1:0]   tag,
    output logic [31:0]            result,
    output logic                   next_e_exists,
    output logic [$clog2(DEPTH):0] next_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [CW-1:0]        r_count;

    logic [DEPTH-1:0]     w_confirmed;
    logic [DEPTH-1:0]     w_survive;
    logic [ROB_WIDTH-1:0] w_tag [DEPTH];
    logic [CW-1:0]        w_survivors;

    logic w_empty;
    logic w_bypass_cand;
    logic w_gc_valid;
    logic w_dispatch;
    logic w_head_dispatch;
    logic w_bypass_dispatch;
    logic w_issue_ready;
    logic w_enq;

    assign w_empty = (r_count == '0);

`ifdef NEXT_BYPASS_EN
    assign w_bypass_cand = w_empty && issue_req.valid && !failure && (b_count_next == '0);
`else
    assign w_bypass_cand = 1'b0;
`endif

    // gc_req.valid must not look at gc_req.ready, only at CDB ready and flush.
    assign w_gc_valid        = gpr_cdb_req.ready && !failure
                             && (w_confirmed[r_head] || w_bypass_cand);
    assign w_dispatch        = w_gc_valid && gc_req.ready;
    assign w_head_dispatch   = w_dispatch && !w_empty;
    assign w_bypass_dispatch = w_dispatch && w_empty;

`ifdef NEXT_BYPASS_EN
    assign w_issue_ready = (r_count < CW'(DEPTH)) || w_dispatch;
`else
    assign w_issue_ready = (r_count < CW'(DEPTH));
`endif

    assign w_enq = issue_req.valid && w_issue_ready && !failure && !w_bypass_dispatch;

    assign issue_req.ready   = w_issue_ready;
    assign gc_req.valid      = w_gc_valid;
    assign gpr_cdb_req.valid = w_dispatch;
    assign tag               = w_empty ? gpr_issue_tag : w_tag[r_head];
    assign result            = sext_gc(gc);
    assign next_e_exists     = !w_empty;
    assign next_count        = r_count;

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        next_slot u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_write     (w_enq && (r_tail == PW'(i))),
            .i_tag       (gpr_issue_tag),
            .i_b_count   (b_count_next),
            .i_clear     (w_head_dispatch && (r_head == PW'(i))),
            .i_flush     (failure),
            .i_b_commit  (b_commit),
            .o_tag       (w_tag[i]),
            .o_confirmed (w_confirmed[i]),
            .o_survive   (w_survive[i])
        );
    end

    // Survivors of a flush form a prefix from head, so counting them locates the new tail.
    always_comb begin
        w_survivors = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_survivors = w_survivors + CW'(w_survive[i]);
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (failure) begin
            r_tail  <= r_head + PW'(w_survivors);
            r_count <= w_survivors;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end else begin
                r_tail <= r_tail;
            end
            if (w_head_dispatch) begin
                r_head <= r_head + PW'(1);
            end else begin
                r_head <= r_head;
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_head_dispatch);
        end
    end

endmodule

// File: tb/tb_next_queue.sv
// Directed self-checking bench for next_queue; expectations adapt to NEXT_BYPASS_EN.
module tb_next_queue;
    import next_queue_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic [ROB_WIDTH-1:0] gpr_issue_tag;
    logic [BC_WIDTH-1:0]  b_count_next;
    logic                 b_commit;
    logic                 failure;
    logic [GC_WIDTH-1:0]  gc;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          result;
    logic                 next_e_exists;
    logic [2:0]           next_count;

    int n_tests = 0;
    int n_fail  = 0;

    next_queue_if issue_if ();
    next_queue_if gc_if ();
    next_queue_if cdb_if ();

    next_queue #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .gpr_issue_tag (gpr_issue_tag),
        .b_count_next  (b_count_next),
        .b_commit      (b_commit),
        .failure       (failure),
        .issue_req     (issue_if),
        .gc_req        (gc_if),
        .gpr_cdb_req   (cdb_if),
        .gc            (gc),
        .tag           (tag),
        .result        (result),
        .next_e_exists (next_e_exists),
        .next_count    (next_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        gpr_issue_tag = 6'd7;
        #1;
        n_tests++; if (issue_if.ready !== 1'b1) begin $display("FAIL reset_issue_ready: got %b want 1", issue_if.ready); n_fail++; end
        n_tests++; if (gc_if.valid !== 1'b0) begin $display("FAIL reset_gc_valid: got %b want 0", gc_if.valid); n_fail++; end
        n_tests++; if (cdb_if.valid !== 1'b0) begin $display("FAIL reset_cdb_valid: got %b want 0", cdb_if.valid); n_fail++; end
        n_tests++; if (next_e_exists !== 1'b0) begin $display("FAIL reset_exists: got %b want 0", next_e_exists); n_fail++; end
        n_tests++; if (next_count !== 3'd0) begin $display("FAIL reset_count: got %0d want 0", next_count); n_fail++; end
        n_tests++; if (tag !== 6'd7) begin $display("FAIL reset_tag: got %0d want 7", tag); n_fail++; end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        step();
        issue_if.valid = 1'b1; gpr_issue_tag = 6'd5; b_count_next = '0; gc = 16'hFFFE;
        gc_if.ready = 1'b1; cdb_if.ready = 1'b1;
        @(negedge clk);
`ifdef NEXT_BYPASS_EN
        n_tests++; if (cdb_if.valid !== 1'b1) begin $display("FAIL basic_bypass_cdb: got %b want 1", cdb_if.valid); n_fail++; end
        n_tests++; if (tag !== 6'd5) begin $display("FAIL basic_bypass_tag: got %0d want 5", tag); n_fail++; end
        n_tests++; if (result !== 32'hFFFF_FFFE) begin $display("FAIL basic_bypass_result: got %h want fffffffe", result); n_fail++; end
`else
        n_tests++; if (cdb_if.valid !== 1'b0) begin $display("FAIL basic_no_early_cdb: got %b want 0", cdb_if.valid); n_fail++; end
`endif
        step();
        issue_if.valid = 1'b0;
        @(negedge clk);
`ifdef NEXT_BYPASS_EN
        n_tests++; if (next_count !== 3'd0) begin $display("FAIL basic_bypass_count: got %0d want 0", next_count); n_fail++; end
        n_tests++; if (cdb_if.valid !== 1'b0) begin $display("FAIL basic_bypass_no_dup: got %b want 0", cdb_if.valid); n_fail++; end
`else
        n_tests++; if (next_count !== 3'd1) begin $display("FAIL basic_count: got %0d want 1", next_count); n_fail++; end
        n_tests++; if (cdb_if.valid !== 1'b1) begin $display("FAIL basic_cdb: got %b want 1", cdb_if.valid); n_fail++; end
        n_tests++; if (tag !== 6'd5) begin $display("FAIL basic_tag: got %0d want 5", tag); n_fail++; end
        n_tests++; if (result !== 32'hFFFF_FFFE) begin $display("FAIL basic_result: got %h want fffffffe", result); n_fail++; end
`endif
        step();
        @(negedge clk);
        n_tests++; if (next_count !== 3'd0) begin $display("FAIL basic_drained: got %0d want 0", next_count); n_fail++; end
    endtask

    task automatic test_branch();
        step();
        issue_if.valid = 1'b1; gpr_issue_tag = 6'd3; b_count_next = 3'd2;
        @(negedge clk);
        n_tests++; if (gc_if.valid !== 1'b0) begin $display("FAIL branch_issue_gc: got %b want 0", gc_if.valid); n_fail++; end
        step();
        issue_if.valid = 1'b0;
        @(negedge clk);
        n_tests++; if (next_count !== 3'd1) begin $display("FAIL branch_count: got %0d want 1", next_count); n_fail++; end
        n_tests++; if (gc_if.valid !== 1'b0) begin $display("FAIL branch_wait_gc: got %b want 0", gc_if.valid); n_fail++; end
        step();
        b_commit = 1'b1;
        @(negedge clk);
        n_tests++; if (gc_if.valid !== 1'b0) begin $display("FAIL branch_commit1_gc: got %b want 0", gc_if.valid); n_fail++; end
        step();
        @(negedge clk);
        n_tests++; if (gc_if.valid !== 1'b1) begin $display("FAIL branch_commit2_gc: got %b want 1", gc_if.valid); n_fail++; end
        n_tests++; if (cdb_if.valid !== 1'b1) begin $display("FAIL branch_commit2_cdb: got %b want 1", cdb_if.valid); n_fail++; end
        n_tests++; if (tag !== 6'd3) begin $display("FAIL branch_tag: got %0d want 3", tag); n_fail++; end
        step();
        b_commit = 1'b0;
        @(negedge clk);
        n_tests++; if (next_count !== 3'd0) begin $display("FAIL branch_drained: got %0d want 0", next_count); n_fail++; end
    endtask

    task automatic test_flush();
        logic [BC_WIDTH-1:0] bcs [4];
        bcs[0] = 3'd0; bcs[1] = 3'd0; bcs[2] = 3'd1; bcs[3] = 3'd2;
        gc_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            issue_if.valid = 1'b1; gpr_issue_tag = 6'(10 + i); b_count_next = bcs[i];
        end
        step();
        issue_if.valid = 1'b0;
        @(negedge clk);
        n_tests++; if (next_count !== 3'd4) begin $display("FAIL flush_full_count: got %0d want 4", next_count); n_fail++; end
        n_tests++; if (issue_if.ready !== 1'b0) begin $display("FAIL flush_full_ready: got %b want 0", issue_if.ready); n_fail++; end
        step();
        failure = 1'b1; issue_if.valid = 1'b1; gpr_issue_tag = 6'd14; b_count_next = '0;
        @(negedge clk);
        n_tests++; if (gc_if.valid !== 1'b0) begin $display("FAIL flush_gc_blocked: got %b want 0", gc_if.valid); n_fail++; end
        step();
        failure = 1'b0; issue_if.valid = 1'b0; gc_if.ready = 1'b1;
        @(negedge clk);
        n_tests++; if (next_count !== 3'd2) begin $display("FAIL flush_survivors: got %0d want 2", next_count); n_fail++; end
        n_tests++; if (cdb_if.valid !== 1'b1 || tag !== 6'd10) begin $display("FAIL flush_first: got valid=%b tag=%0d want valid=1 tag=10", cdb_if.valid, tag); n_fail++; end
        step();
        @(negedge clk);
        n_tests++; if (cdb_if.valid !== 1'b1 || tag !== 6'd11) begin $display("FAIL flush_second: got valid=%b tag=%0d want valid=1 tag=11", cdb_if.valid, tag); n_fail++; end
        step();
        @(negedge clk);
        n_tests++; if (next_count !== 3'd0 || cdb_if.valid !== 1'b0) begin $display("FAIL flush_drained: got count=%0d valid=%b want 0 0", next_count, cdb_if.valid); n_fail++; end
    endtask

    task automatic test_full();
        int exp_q[$];
        gc_if.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            issue_if.valid = 1'b1; gpr_issue_tag = 6'(30 + i); b_count_next = '0;
        end
        step();
        gpr_issue_tag = 6'd20; gc_if.ready = 1'b1;
        @(negedge clk);
        n_tests++; if (cdb_if.valid !== 1'b1 || tag !== 6'd30) begin $display("FAIL full_head: got valid=%b tag=%0d want valid=1 tag=30", cdb_if.valid, tag); n_fail++; end
`ifdef NEXT_BYPASS_EN
        n_tests++; if (issue_if.ready !== 1'b1) begin $display("FAIL full_ready_bypass: got %b want 1", issue_if.ready); n_fail++; end
        step();
        issue_if.valid = 1'b0;
        @(negedge clk);
        n_tests++; if (next_count !== 3'd4) begin $display("FAIL full_count_bypass: got %0d want 4", next_count); n_fail++; end
        exp_q = '{31, 32, 33, 20};
`else
        n_tests++; if (issue_if.ready !== 1'b0) begin $display("FAIL full_ready: got %b want 0", issue_if.ready); n_fail++; end
        step();
        @(negedge clk);
        n_tests++; if (issue_if.ready !== 1'b1 || next_count !== 3'd3) begin $display("FAIL full_retry: got ready=%b count=%0d want 1 3", issue_if.ready, next_count); n_fail++; end
        n_tests++; if (tag !== 6'd31) begin $display("FAIL full_second_head: got %0d want 31", tag); n_fail++; end
        step();
        issue_if.valid = 1'b0;
        @(negedge clk);
        n_tests++; if (next_count !== 3'd3) begin $display("FAIL full_count: got %0d want 3", next_count); n_fail++; end
        exp_q = '{32, 33, 20};
`endif
        foreach (exp_q[k]) begin
            n_tests++; if (cdb_if.valid !== 1'b1 || tag !== 6'(exp_q[k])) begin $display("FAIL full_drain_%0d: got valid=%b tag=%0d want valid=1 tag=%0d", k, cdb_if.valid, tag, exp_q[k]); n_fail++; end
            step();
            @(negedge clk);
        end
        n_tests++; if (next_count !== 3'd0) begin $display("FAIL full_drained: got %0d want 0", next_count); n_fail++; end
    endtask

    task automatic test_back_to_back();
        step();
        gc_if.ready = 1'b0; issue_if.valid = 1'b1; gpr_issue_tag = 6'd40; b_count_next = '0;
        for (int i = 1; i <= 12; i++) begin
            step();
            gc_if.ready = 1'b1; gpr_issue_tag = 6'(40 + i);
            gc = (i == 1) ? 16'h1234 : 16'h8001;
            @(negedge clk);
            n_tests++; if (cdb_if.valid !== 1'b1 || tag !== 6'(40 + i - 1) || next_count !== 3'd1) begin
                $display("FAIL b2b_%0d: got valid=%b tag=%0d count=%0d want valid=1 tag=%0d count=1", i, cdb_if.valid, tag, next_count, 40 + i - 1); n_fail++;
            end
            if (i == 1) begin
                n_tests++; if (result !== 32'h0000_1234) begin $display("FAIL b2b_result_pos: got %h want 00001234", result); n_fail++; end
            end else if (i == 2) begin
                n_tests++; if (result !== 32'hFFFF_8001) begin $display("FAIL b2b_result_neg: got %h want ffff8001", result); n_fail++; end
            end
        end
        step();
        issue_if.valid = 1'b0;
        @(negedge clk);
        n_tests++; if (cdb_if.valid !== 1'b1 || tag !== 6'd52) begin $display("FAIL b2b_last: got valid=%b tag=%0d want valid=1 tag=52", cdb_if.valid, tag); n_fail++; end
        step();
        @(negedge clk);
        n_tests++; if (next_count !== 3'd0 || cdb_if.valid !== 1'b0) begin $display("FAIL b2b_drained: got count=%0d valid=%b want 0 0", next_count, cdb_if.valid); n_fail++; end
    endtask

    task automatic test_async_reset();
        gc_if.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            issue_if.valid = 1'b1; gpr_issue_tag = 6'(50 + i); b_count_next = '0;
        end
        step();
        issue_if.valid = 1'b0;
        @(negedge clk);
        n_tests++; if (gc_if.valid !== 1'b1 || next_count !== 3'd3) begin $display("FAIL areset_pre: got gc_valid=%b count=%0d want 1 3", gc_if.valid, next_count); n_fail++; end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if (gc_if.valid !== 1'b0) begin $display("FAIL areset_gc_valid: got %b want 0", gc_if.valid); n_fail++; end
        n_tests++; if (next_e_exists !== 1'b0 || next_count !== 3'd0) begin $display("FAIL areset_state: got exists=%b count=%0d want 0 0", next_e_exists, next_count); n_fail++; end
        @(negedge clk);
        rst_n = 1'b1; gc_if.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (cdb_if.valid !== 1'b0) begin $display("FAIL areset_no_cdb_%0d: got %b want 0", i, cdb_if.valid); n_fail++; end
            @(negedge clk);
        end
    endtask

    initial begin
        issue_if.valid = 1'b0;
        gc_if.ready    = 1'b1;
        cdb_if.ready   = 1'b1;
        b_count_next   = '0;
        b_commit       = 1'b0;
        failure        = 1'b0;
        gc             = '0;
        test_reset();
        test_basic();
        test_branch();
        test_flush();
        test_full();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
